noc_endpoint: RTL



---
 rtl/noc_pkg.sv | 31 +++
 rtl/endpoint_rx_fifo.sv | 43 ++++
 rtl/noc_endpoint.sv | 95 +++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared flit format and defaults for the mesh endpoint.
// A flit is {payload, dest_x, dest_y}; every flit is routed on its own.
package noc_pkg;

  localparam int FLIT_W           = 16;
  localparam int PAYLOAD_W        = 8;
  localparam int COORD_W          = 4;
  localparam int PAYLOAD_LSB      = 8;
  localparam int DEST_X_LSB       = 4;
  localparam int DEST_Y_LSB       = 0;
  localparam int DEFAULT_CREDITS  = 4;
  localparam int DEFAULT_RX_DEPTH = 4;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [COORD_W-1:0]   dest_x;
    logic [COORD_W-1:0]   dest_y;
  } flit_t;

  function automatic flit_t make_flit(input logic [PAYLOAD_W-1:0] payload,
                                      input logic [COORD_W-1:0]   dest_x,
                                      input logic [COORD_W-1:0]   dest_y);
    logic [FLIT_W-1:0] f;
    f = '0;
    f[PAYLOAD_LSB +: PAYLOAD_W] = payload;
    f[DEST_X_LSB  +: COORD_W]   = dest_x;
    f[DEST_Y_LSB  +: COORD_W]   = dest_y;
    return flit_t'(f);
  endfunction

endpackage

// File: rtl/endpoint_rx_fifo.sv
// Receive buffer for the endpoint. The caller only pushes when accepted and only pops
// when non-empty; a push while full is legal only together with a pop.
module endpoint_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit tells a full buffer apart from an empty one.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/noc_endpoint.sv
// Mesh network endpoint: credit-based flit transmit toward the router local input and
// a buffered, credit-returning receive path toward the core, with sticky error flags.
module noc_endpoint
  import noc_pkg::*;
#(
  parameter int XCOORD   = 0,
  parameter int YCOORD   = 0,
  parameter int CREDITS  = DEFAULT_CREDITS,
  parameter int RX_DEPTH = DEFAULT_RX_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [COORD_W-1:0]   tx_dest_x,
  input  logic [COORD_W-1:0]   tx_dest_y,
  input  logic [PAYLOAD_W-1:0] tx_payload,
  output logic [FLIT_W-1:0]    net_tx_data,
  output logic                 net_tx_enable,
  input  logic                 net_tx_credit,
  input  logic [FLIT_W-1:0]    net_rx_data,
  input  logic                 net_rx_enable,
  output logic                 net_rx_credit,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [FLIT_W-1:0]    rx_data,
  output logic                 err_rx_overflow,
  output logic                 err_credit_overflow,
  output logic                 err_misroute
);

  localparam logic [3:0]         CREDIT_MAX = 4'(CREDITS);
  localparam logic [COORD_W-1:0] MY_X       = COORD_W'(XCOORD);
  localparam logic [COORD_W-1:0] MY_Y       = COORD_W'(YCOORD);

  logic [3:0] credit_cnt;
  logic       send;
  logic       rx_full;
  logic       rx_empty;
  logic       rx_pop;
  logic       rx_push;
  logic       rx_misrouted;

  // tx_ready comes straight from the credit register so the core sees no combinational loop.
  assign tx_ready = (credit_cnt != 4'd0);
  assign send     = tx_valid && tx_ready;

  assign rx_valid     = !rx_empty;
  assign rx_pop       = rx_valid && rx_ready;
  assign rx_push      = net_rx_enable && (!rx_full || rx_pop);
  assign rx_misrouted = (net_rx_data[DEST_X_LSB +: COORD_W] != MY_X) ||
                        (net_rx_data[DEST_Y_LSB +: COORD_W] != MY_Y);

  // NOTE: all registered state uses non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_cnt          <= CREDIT_MAX;
      net_tx_enable       <= 1'b0;
      net_tx_data         <= '0;
      net_rx_credit       <= 1'b0;
      err_rx_overflow     <= 1'b0;
      err_credit_overflow <= 1'b0;
      err_misroute        <= 1'b0;
    end else begin
      net_tx_enable <= send;
      if (send) net_tx_data <= make_flit(tx_payload, tx_dest_x, tx_dest_y);

      if (send && !net_tx_credit) begin
        credit_cnt <= credit_cnt - 4'd1;
      end else if (!send && net_tx_credit) begin
        if (credit_cnt == CREDIT_MAX) err_credit_overflow <= 1'b1;
        else                          credit_cnt <= credit_cnt + 4'd1;
      end

      net_rx_credit <= rx_pop;
      if (net_rx_enable && !rx_push) err_rx_overflow <= 1'b1;
      if (rx_push && rx_misrouted)   err_misroute    <= 1'b1;
    end
  end

  endpoint_rx_fifo #(
    .DEPTH (RX_DEPTH),
    .WIDTH (FLIT_W)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (net_rx_data),
    .dout  (rx_data),
    .full  (rx_full),
    .empty (rx_empty)
  );

endmodule
